mux_sel_step: RTL and testbench
===============================

# mux_sel_step

Parametrised N-channel, W-bit registered multiplexer whose channel selector is stepped up or down by two active-low push-buttons, each synchronised and debounced inside the block. It generalises the board-level 2:1 key/LED mux exercises into a reusable selector for EPM240-class boards: the board top inverts raw key and LED polarity, and this block handles synchronisation, debouncing, wrap-around selection and output registration.

## Interface
Parameters:
- N_CH, 4: number of input channels, 2..16.
- W, 4: bits per channel, 1..16.
- DEBOUNCE_CYCLES, 16: consecutive stable synchronised samples required to accept a key change, 1..65535.
- AUTO_PERIOD, 1000: cycles between automatic advances; used only when MUX_SEL_AUTO_EN is defined.

Ports (SEL_W = $clog2(N_CH)):
- clk  in  1  system clock; one clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- in_data  in  N_CH*W  channel c occupies bits [c*W +: W]; active-high; treated as static or slow data.
- key_next_n  in  1  raw active-low button, asynchronous; a press increments sel.
- key_prev_n  in  1  raw active-low button, asynchronous; a press decrements sel.
- out_data  out  W  registered copy of the selected channel.
- sel  out  SEL_W  current channel index.
- step  out  1  one-cycle pulse on the cycle sel changes.

## Operation
- Each key passes through a 2-flop synchroniser and then a debouncer.
- The debounced state starts as released. It changes only after the synchronised value differs from it for DEBOUNCE_CYCLES consecutive cycles. Any agreeing sample clears the counter.
- A press event is the debounced released-to-pressed transition. A release produces no event.
- Selection rules:
  - next event only: sel = (sel == N_CH-1) ? 0 : sel+1.
  - prev event only: sel = (sel == 0) ? N_CH-1 : sel-1.
  - both events in the same cycle: sel unchanged and step stays 0.
- Holding a key produces exactly one step. There is no auto-repeat.
- out_data is registered from in_data[sel*W +: W] on every clock, so input changes on the current channel also propagate.
- Reset values: sel=0, out_data=0, step=0, synchronisers at 1 (released), debounced state released, all counters 0.
- Reset asserted mid-debounce or mid-step discards the partial count. After release, a key still held low must debounce again and then steps once.

## Timing
- Raw key held low from edge k: sync output is low at edge k+2.
- The debounced state and sel update at edge k+2+DEBOUNCE_CYCLES, and step is high for the following cycle.
- out_data shows the new channel at edge k+3+DEBOUNCE_CYCLES.
- A glitch shorter than DEBOUNCE_CYCLES synchronised cycles produces no step.
- in_data change to latency out_data: 1 cycle.

## Configuration
- With MUX_SEL_AUTO_EN defined:
  - A free-running counter advances sel by +1, with wrap and a step pulse, every AUTO_PERIOD cycles.
  - A manual event in the same cycle takes priority over the auto advance, and the both-keys case still holds sel.
  - Any manual event reloads the auto counter, so the next auto advance comes AUTO_PERIOD cycles after it.
  - Auto counter resets to 0.
- Without the macro: no auto counter is synthesised, AUTO_PERIOD is ignored, and sel changes only on key events.

## Structure
- Package mux_sel_pkg: a function computing SEL_W, the inc/dec wrap helper functions, and the key-released constant 1'b1.
- Sub-module key_debounce (parameter DEBOUNCE_CYCLES):
  - contains the synchroniser, stable counter and debounced state;
  - outputs a press pulse;
  - instantiated once per key.
- Top level holds the selector register, the optional auto counter, and the output register and mux.

## Test plan
Configuration for all scenarios: N_CH=4, W=4, DEBOUNCE_CYCLES=4, in_data channels 0..3 = 4'h1, 4'h2, 4'h4, 4'h8.
- Reset then idle 20 cycles -> sel=0, out_data=4'h1, step never high.
- key_next_n low from edge 10 and held 30 cycles -> sel=1 at edge 16, step high for 1 cycle, out_data=4'h2 at edge 17, no further steps while held.
- Four next presses, each released for ≥8 cycles -> sel sequence 1,2,3,0; out_data returns to 4'h1. One prev press from sel=0 -> sel=3, out_data=4'h8.
- key_next_n low for 3 cycles, repeated as bounces -> no step. Both keys pressed on the same edge -> debounce completes together, sel unchanged, step=0.
- rst_n asserted 2 cycles into a debounce, released with the key still held -> sel=0 during reset, then exactly one step 6 cycles after rst_n rises.
- MUX_SEL_AUTO_EN with AUTO_PERIOD=50 and no keys -> sel advances every 50 cycles with wrap. A next press completing 10 cycles before an auto advance -> sel+1 at once, next auto advance 50 cycles after the press.

Source files
------------

// File: rtl/mux_sel_pkg.sv
// Shared helpers for mux_sel_step: selector width, wrap-around stepping and
// the released level of the active-low keys.
package mux_sel_pkg;

  localparam logic KEY_RELEASED = 1'b1;

  function automatic int sel_width(input int n_ch);
    return (n_ch > 1) ? $clog2(n_ch) : 1;
  endfunction

  function automatic int unsigned wrap_inc(input int unsigned v, input int unsigned n);
    return (v == n - 1) ? 0 : v + 1;
  endfunction

  function automatic int unsigned wrap_dec(input int unsigned v, input int unsigned n);
    return (v == 0) ? n - 1 : v - 1;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Two-flop synchroniser plus stable-count debouncer for one active-low key;
// emits a single-cycle press pulse on the debounced released-to-pressed edge.
module key_debounce
  import mux_sel_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic press
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q, sync_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             db_q, db_d;
  logic             key_s;

  assign key_s = sync_q[1];

  // NOTE: every always_comb output gets a default first, so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    sync_d = {sync_q[0], key_n};
    cnt_d  = '0;
    db_d   = db_q;
    // The counter holds how many consecutive samples have disagreed so far;
    // the last disagreeing sample flips the state instead of counting.
    if (key_s != db_q) begin
      if (cnt_q == CNT_LAST) db_d = key_s;
      else                   cnt_d = cnt_q + CNT_W'(1);
    end
    press = (db_q == KEY_RELEASED) && (db_d != KEY_RELEASED);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {2{KEY_RELEASED}};
      cnt_q  <= '0;
      db_q   <= KEY_RELEASED;
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
      db_q   <= db_d;
    end
  end

endmodule

// File: rtl/mux_sel_step.sv
// N-channel registered mux whose selector is stepped by two debounced keys.
// Define MUX_SEL_AUTO_EN to add a free-running auto-advance every AUTO_PERIOD cycles.
module mux_sel_step
  import mux_sel_pkg::*;
#(
  parameter  int N_CH            = 4,
  parameter  int W               = 4,
  parameter  int DEBOUNCE_CYCLES = 16,
  parameter  int AUTO_PERIOD     = 1000,
  localparam int SEL_W           = sel_width(N_CH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_CH*W-1:0] in_data,
  input  logic              key_next_n,
  input  logic              key_prev_n,
  output logic [W-1:0]      out_data,
  output logic [SEL_W-1:0]  sel,
  output logic              step
);

  logic             next_press, prev_press;
  logic             next_ev, prev_ev, manual_ev;
  logic [SEL_W-1:0] sel_q, sel_d, sel_inc, sel_dec;
  logic             step_q, step_d;
  logic [W-1:0]     out_data_q, out_data_d;

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_next (
    .clk   (clk),
    .rst_n (rst_n),
    .key_n (key_next_n),
    .press (next_press)
  );

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_prev (
    .clk   (clk),
    .rst_n (rst_n),
    .key_n (key_prev_n),
    .press (prev_press)
  );

  assign next_ev   = next_press && !prev_press;
  assign prev_ev   = prev_press && !next_press;
  assign manual_ev = next_press || prev_press;
  assign sel_inc   = SEL_W'(wrap_inc(32'(sel_q), N_CH));
  assign sel_dec   = SEL_W'(wrap_dec(32'(sel_q), N_CH));

`ifdef MUX_SEL_AUTO_EN
  localparam int AUTO_W = (AUTO_PERIOD > 1) ? $clog2(AUTO_PERIOD) : 1;
  localparam logic [AUTO_W-1:0] AUTO_LAST = AUTO_W'(AUTO_PERIOD - 1);

  logic [AUTO_W-1:0] auto_cnt_q, auto_cnt_d;
`else
  // The auto-advance parameter only matters when the feature is built in.
  localparam int unused_auto_period = AUTO_PERIOD;
`endif

  always_comb begin
    sel_d  = sel_q;
    step_d = 1'b0;
    if (next_ev) begin
      sel_d  = sel_inc;
      step_d = 1'b1;
    end else if (prev_ev) begin
      sel_d  = sel_dec;
      step_d = 1'b1;
    end
`ifdef MUX_SEL_AUTO_EN
    // Any key event, including both at once, restarts the auto period and
    // suppresses an auto advance landing on the same cycle.
    auto_cnt_d = auto_cnt_q + AUTO_W'(1);
    if (manual_ev) begin
      auto_cnt_d = '0;
    end else if (auto_cnt_q == AUTO_LAST) begin
      auto_cnt_d = '0;
      sel_d      = sel_inc;
      step_d     = 1'b1;
    end
`endif
  end

  always_comb begin
    out_data_d = '0;
    for (int c = 0; c < N_CH; c++) begin
      if (sel_q == SEL_W'(c)) out_data_d = in_data[c*W +: W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q      <= '0;
      step_q     <= 1'b0;
      out_data_q <= '0;
`ifdef MUX_SEL_AUTO_EN
      auto_cnt_q <= '0;
`endif
    end else begin
      sel_q      <= sel_d;
      step_q     <= step_d;
      out_data_q <= out_data_d;
`ifdef MUX_SEL_AUTO_EN
      auto_cnt_q <= auto_cnt_d;
`endif
    end
  end

  assign out_data = out_data_q;
  assign sel      = sel_q;
  assign step     = step_q;

  logic unused_manual;
  assign unused_manual = manual_ev;

endmodule

// File: tb/tb_mux_sel_step.sv
// Directed bench for mux_sel_step (N_CH=4, W=4, DEBOUNCE_CYCLES=4); exercises
// the auto-advance path instead when MUX_SEL_AUTO_EN is defined.
module tb_mux_sel_step;

  localparam int N_CH = 4;
  localparam int W    = 4;
  localparam int DB   = 4;
  localparam int AP   = 50;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N_CH*W-1:0] in_data;
  logic              key_next_n, key_prev_n;
  logic [W-1:0]      out_data;
  logic [1:0]        sel;
  logic              step;

  int n_checks = 0;
  int n_bad    = 0;
  int step_cnt = 0;
  int base;

  mux_sel_step #(
    .N_CH(N_CH), .W(W), .DEBOUNCE_CYCLES(DB), .AUTO_PERIOD(AP)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_data    (in_data),
    .key_next_n (key_next_n),
    .key_prev_n (key_prev_n),
    .out_data   (out_data),
    .sel        (sel),
    .step       (step)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (step === 1'b1) step_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press_key(input bit nxt, input bit prv);
    if (nxt) key_next_n = 1'b0;
    if (prv) key_prev_n = 1'b0;
    tick(8);
    key_next_n = 1'b1;
    key_prev_n = 1'b1;
    tick(10);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(3);
    check("reset_sel",  32'(sel), 0);
    check("reset_out",  32'(out_data), 0);
    check("reset_step", 32'(step), 0);
    rst_n = 1'b1;
  endtask

  task automatic manual_tests();
    int exp_seq [3] = '{2, 3, 0};
    do_reset();
    tick(20);
    check("idle_sel", 32'(sel), 0);
    check("idle_out", 32'(out_data), 32'h1);
    check("idle_steps", 32'(step_cnt), 0);

    // Hold next from edge k: sel moves at k+6, out_data at k+7.
    base = step_cnt;
    key_next_n = 1'b0;
    tick(5);
    check("hold_early_sel", 32'(sel), 0);
    tick(1);
    check("hold_sel", 32'(sel), 1);
    check("hold_step", 32'(step), 1);
    check("hold_out_lag", 32'(out_data), 32'h1);
    tick(1);
    check("hold_out", 32'(out_data), 32'h2);
    check("hold_step_low", 32'(step), 0);
    tick(23);
    check("hold_one_step", 32'(step_cnt - base), 1);
    key_next_n = 1'b1;
    tick(10);
    check("release_no_step", 32'(step_cnt - base), 1);

    for (int i = 0; i < 3; i++) begin
      press_key(1'b1, 1'b0);
      check($sformatf("next_seq%0d", i), 32'(sel), 32'(exp_seq[i]));
    end
    check("wrap_out", 32'(out_data), 32'h1);
    press_key(1'b0, 1'b1);
    check("prev_wrap_sel", 32'(sel), 3);
    check("prev_wrap_out", 32'(out_data), 32'h8);

    // Three-cycle pulses never reach the four-sample threshold.
    base = step_cnt;
    repeat (3) begin
      key_next_n = 1'b0;
      tick(3);
      key_next_n = 1'b1;
      tick(3);
    end
    tick(10);
    check("bounce_steps", 32'(step_cnt - base), 0);
    check("bounce_sel", 32'(sel), 3);

    base = step_cnt;
    press_key(1'b1, 1'b1);
    check("both_sel", 32'(sel), 3);
    check("both_steps", 32'(step_cnt - base), 0);

    // Reset two cycles into a debounce; the held key must debounce afresh.
    key_next_n = 1'b0;
    tick(2);
    rst_n = 1'b0;
    tick(1);
    check("midrst_sel", 32'(sel), 0);
    check("midrst_out", 32'(out_data), 0);
    tick(2);
    rst_n = 1'b1;
    base = step_cnt;
    tick(5);
    check("postrst_early_sel", 32'(sel), 0);
    tick(1);
    check("postrst_sel", 32'(sel), 1);
    check("postrst_step", 32'(step), 1);
    tick(10);
    key_next_n = 1'b1;
    tick(10);
    check("postrst_one_step", 32'(step_cnt - base), 1);

    base = step_cnt;
    tick(120);
    check("no_auto_sel", 32'(sel), 1);
    check("no_auto_steps", 32'(step_cnt - base), 0);
  endtask

  task automatic auto_tests();
    do_reset();
    tick(49);
    check("auto_early_sel", 32'(sel), 0);
    tick(1);
    check("auto_first_sel", 32'(sel), 1);
    check("auto_first_step", 32'(step), 1);
    tick(150);
    check("auto_wrap_sel", 32'(sel), 0);
    check("auto_wrap_out", 32'(out_data), 32'h8);
    // Press from edge r+234 completes at r+240, ten cycles before auto.
    tick(34);
    key_next_n = 1'b0;
    tick(5);
    check("auto_press_early", 32'(sel), 0);
    tick(1);
    check("auto_press_sel", 32'(sel), 1);
    tick(2);
    key_next_n = 1'b1;
    tick(8);
    check("auto_reloaded", 32'(sel), 1);
    tick(39);
    check("auto_after_press_early", 32'(sel), 1);
    tick(1);
    check("auto_after_press_sel", 32'(sel), 2);
    check("auto_after_press_step", 32'(step), 1);
  endtask

  initial begin
    rst_n      = 1'b0;
    key_next_n = 1'b1;
    key_prev_n = 1'b1;
    in_data    = 16'h8421;
`ifdef MUX_SEL_AUTO_EN
    auto_tests();
`else
    manual_tests();
`endif
    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
